// File: rtl/rv_decode_exec_mem.sv
// rv_decode_exec_mem
// Decode / execute / data-memory slice of a single-cycle RV32I-subset core.
// Holds the 32x32 register file and a word-addressed data memory, decodes
// the immediates from the current instruction and runs the ALU. Every output
// is combinational from the inputs and the current state; the register file
// and memory update on the rising edge of clk.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset (regfile only)
//   ins              current instruction from fetch
//   wd, RegWrite     register write data / enable (destination ins[11:7])
//   ALUSrc           0: ALU operand B = rd2, 1: operand B = imm
//   op               ALU operation select
//   MemRead/MemWrite data-memory read / write enables
//   rd1, rd2         register[ins[19:15]], register[ins[24:20]]
//   imm              opcode-selected, sign-extended immediate
//   jTarget, branch  J-type / B-type offsets (unscaled, sign-extended)
//   z, zero          ALU result (also memory byte address), z == 0 flag
//   memOut           data-memory read data (0 when MemRead is low)
module rv_decode_exec_mem #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic [31:0] wd,
  input  logic        RegWrite,
  input  logic        ALUSrc,
  input  logic [2:0]  op,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] imm,
  output logic [31:0] jTarget,
  output logic [31:0] branch,
  output logic [31:0] z,
  output logic        zero,
  output logic [31:0] memOut
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [4:0]  rs1, rs2, rd;
  logic [31:0] regs [32];
  logic [31:0] dmem [DM_WORDS];
  logic [31:0] opb;
  logic [AW-1:0] widx;

  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  // Register file. Entry 0 is never written, and reads of x0 are forced
  // to zero as well so it does not depend on entry 0's value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWrite && (rd != 5'd0)) begin
      regs[rd] <= wd;
    end
  end

  assign rd1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  // Offsets are left unscaled; the caller applies the half-word shift.
  assign branch  = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
  assign jTarget = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};

  always_comb begin
    imm = 32'h0;
    case (ins[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:                     imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:                    imm = branch;
      OPC_LUI, OPC_AUIPC:            imm = {ins[31:12], 12'h000};
      OPC_JAL:                       imm = jTarget;
      default:                       imm = 32'h0;
    endcase
  end

  assign opb = ALUSrc ? imm : rd2;

  always_comb begin
    z = 32'h0;
    case (op)
      ALU_AND: z = rd1 & opb;
      ALU_OR:  z = rd1 | opb;
      ALU_ADD: z = rd1 + opb;
      ALU_SUB: z = rd1 - opb;
      ALU_SLT: z = {31'h0, ($signed(rd1) < $signed(opb))};
      default: z = 32'h0;
    endcase
  end

  assign zero = (z == 32'h0);

  // Word index from the byte address: low two bits dropped, bits above
  // the memory depth dropped so addresses wrap. Contents survive reset.
  assign widx = z[AW+1:2];

  always_ff @(posedge clk) begin
    if (MemWrite) dmem[widx] <= rd2;
  end

  assign memOut = MemRead ? dmem[widx] : 32'h0;

endmodule

// File: tb/tb_rv_decode_exec_mem.sv
module tb_rv_decode_exec_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins, wd;
  logic        RegWrite, ALUSrc, MemRead, MemWrite;
  logic [2:0]  op;
  logic [31:0] rd1, rd2, imm, jTarget, branch, z, memOut;
  logic        zero;

  int errors = 0;
  int checks = 0;

  rv_decode_exec_mem #(.DM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .ins(ins), .wd(wd), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead), .MemWrite(MemWrite),
    .rd1(rd1), .rd2(rd2), .imm(imm), .jTarget(jTarget), .branch(branch),
    .z(z), .zero(zero), .memOut(memOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Expected-value record; mask bits: 0 rd1, 1 rd2, 2 imm, 3 jTarget,
  // 4 branch, 5 z, 6 zero, 7 memOut.
  typedef struct {
    string       tag;
    logic [7:0]  mask;
    logic [31:0] rd1, rd2, imm, jt, br, z, mo;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] r1v, r2v, ins;
    logic        alusrc;
    logic [2:0]  op;
    logic [31:0] imm, jt, br, z;
    logic        zero;
  } vec_t;

  vec_t vecs[13];

  task automatic cmp(input string tag, input string fld, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h required 0x%08h", tag, fld, got, expv);
    end
  endtask

  // Pop the oldest expectation and compare against the live outputs.
  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue required an entry");
      return;
    end
    e = sb.pop_front();
    if (e.mask[0]) cmp(e.tag, "rd1", rd1, e.rd1);
    if (e.mask[1]) cmp(e.tag, "rd2", rd2, e.rd2);
    if (e.mask[2]) cmp(e.tag, "imm", imm, e.imm);
    if (e.mask[3]) cmp(e.tag, "jTarget", jTarget, e.jt);
    if (e.mask[4]) cmp(e.tag, "branch", branch, e.br);
    if (e.mask[5]) cmp(e.tag, "z", z, e.z);
    if (e.mask[6]) cmp(e.tag, "zero", {31'h0, zero}, {31'h0, e.zero});
    if (e.mask[7]) cmp(e.tag, "memOut", memOut, e.mo);
  endtask

  task automatic expect1(input string tag, input logic [7:0] mask, input logic [31:0] v);
    exp_t e;
    e = '{tag: tag, mask: mask, rd1: v, rd2: v, imm: v, jt: v, br: v, z: v, mo: v, zero: v[0]};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
    ins = {20'h0, r, 7'h33};
    wd = v; RegWrite = 1'b1; MemWrite = 1'b0;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic drive(input logic [31:0] i, input logic as, input logic [2:0] o,
                       input logic mr, input logic mw);
    ins = i; ALUSrc = as; op = o; MemRead = mr; MemWrite = mw;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    //            r1v           r2v           ins           src op      imm           jt            br            z             zero
    vecs[0]  = '{32'h0,        32'h0,        32'h00A00093, 1'b1, 3'b010, 32'd10,       32'd5,        32'h400,      32'd10,       1'b0};
    vecs[1]  = '{32'd10,       32'd10,       32'h00208463, 1'b0, 3'b110, 32'd4,        32'h4001,     32'd4,        32'd0,        1'b1};
    vecs[2]  = '{32'd10,       32'd7,        32'h0020A1B3, 1'b0, 3'b111, 32'd0,        32'h5001,     32'h401,      32'd0,        1'b1};
    vecs[3]  = '{32'hFFFFFFFF, 32'd7,        32'h0020A1B3, 1'b0, 3'b111, 32'd0,        32'h5001,     32'h401,      32'd1,        1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'd1,        32'h0020A1B3, 1'b0, 3'b010, 32'd0,        32'h5001,     32'h401,      32'd0,        1'b1};
    vecs[5]  = '{32'hF0F01234, 32'h0FF000FF, 32'h0020A1B3, 1'b0, 3'b000, 32'd0,        32'h5001,     32'h401,      32'h00F00034, 1'b0};
    vecs[6]  = '{32'hF0F01234, 32'h0FF000FF, 32'h0020A1B3, 1'b0, 3'b001, 32'd0,        32'h5001,     32'h401,      32'hFFF012FF, 1'b0};
    vecs[7]  = '{32'd5,        32'd3,        32'h0020A1B3, 1'b0, 3'b011, 32'd0,        32'h5001,     32'h401,      32'd0,        1'b1};
    vecs[8]  = '{32'd0,        32'd1,        32'h0020A1B3, 1'b0, 3'b110, 32'd0,        32'h5001,     32'h401,      32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{32'h0,        32'h77,       32'h0100006F, 1'b1, 3'b010, 32'd8,        32'd8,        32'd0,        32'd8,        1'b0};
    vecs[10] = '{32'h0,        32'h0,        32'hFE000EE3, 1'b0, 3'b110, 32'hFFFFFFFE, 32'hFFF803F0, 32'hFFFFFFFE, 32'd0,        1'b1};
    vecs[11] = '{32'd8,        32'h55,       32'h0020A223, 1'b1, 3'b010, 32'd4,        32'h5001,     32'd2,        32'd12,       1'b0};
    vecs[12] = '{32'h100,      32'h0,        32'h12345037, 1'b1, 3'b010, 32'h12345000, 32'h22C91,    32'h90,       32'h12345100, 1'b0};

    reset = 1'b1; ins = 32'h0; wd = 32'h0; RegWrite = 1'b0;
    ALUSrc = 1'b0; op = 3'b000; MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Post-reset: x5/x6 read zero, AND of zeros gives zero flag.
    drive({7'h0, 5'd6, 5'd5, 3'b000, 5'd0, 7'h33}, 1'b0, 3'b000, 1'b0, 1'b0);
    e = '{tag: "reset", mask: 8'b1110_0011, rd1: 0, rd2: 0, imm: 0, jt: 0, br: 0, z: 0, mo: 0, zero: 1'b1};
    sb.push_back(e);
    #2 sample();

    foreach (vecs[k]) begin
      v = vecs[k];
      if (v.ins[19:15] != 5'd0) wr_reg(v.ins[19:15], v.r1v);
      if (v.ins[24:20] != 5'd0) wr_reg(v.ins[24:20], v.r2v);
      drive(v.ins, v.alusrc, v.op, 1'b0, 1'b0);
      e.tag  = $sformatf("vec%0d", k);
      e.mask = 8'hFF;
      e.rd1  = (v.ins[19:15] == 5'd0) ? 32'h0 : v.r1v;
      e.rd2  = (v.ins[24:20] == 5'd0) ? 32'h0 : v.r2v;
      e.imm = v.imm; e.jt = v.jt; e.br = v.br; e.z = v.z; e.zero = v.zero; e.mo = 32'h0;
      sb.push_back(e);
      #2 sample();
    end

    // addi x1,x0,10 written back, then x1 read through rs1.
    drive(32'h00A00093, 1'b1, 3'b010, 1'b0, 1'b0);
    wd = 32'd10; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    drive(32'h00008093, 1'b1, 3'b010, 1'b0, 1'b0);
    expect1("addi_wb", 8'b0000_0001, 32'd10);
    #2 sample();

    // Read-during-write on x1: old value before the edge, new after.
    wd = 32'h321; RegWrite = 1'b1;
    expect1("rdw_old", 8'b0000_0001, 32'd10);
    #2 sample();
    tick();
    RegWrite = 1'b0;
    expect1("rdw_new", 8'b0000_0001, 32'h321);
    #2 sample();

    // Store 0x55 to byte address 12, then load it back.
    wr_reg(5'd1, 32'd8);
    wr_reg(5'd2, 32'h55);
    drive(32'h0020A223, 1'b1, 3'b010, 1'b0, 1'b1);
    expect1("sw_addr", 8'b0010_0000, 32'd12);
    #2 sample();
    tick();
    drive(32'h00C02203, 1'b1, 3'b010, 1'b1, 1'b0);
    expect1("lw_z", 8'b0010_0000, 32'd12);
    #2 sample();
    expect1("lw_data", 8'b1000_0000, 32'h55);
    sample();
    MemRead = 1'b0;
    expect1("lw_noread", 8'b1000_0000, 32'h0);
    #2 sample();

    // Simultaneous read and write of the same word.
    wr_reg(5'd2, 32'hAA);
    drive(32'h0020A223, 1'b1, 3'b010, 1'b1, 1'b1);
    expect1("rw_old", 8'b1000_0000, 32'h55);
    #2 sample();
    tick();
    MemWrite = 1'b0;
    expect1("rw_new", 8'b1000_0000, 32'hAA);
    #2 sample();

    // Address 4096+12 wraps onto word 3.
    wr_reg(5'd1, 32'd4096);
    drive(32'h00C0A203, 1'b1, 3'b010, 1'b1, 1'b0);
    e = '{tag: "wrap", mask: 8'b1010_0000, rd1: 0, rd2: 0, imm: 0, jt: 0, br: 0, z: 32'd4108, mo: 32'hAA, zero: 1'b0};
    sb.push_back(e);
    #2 sample();
    MemRead = 1'b0;

    // Writes to x0 are dropped.
    drive(32'h00000033, 1'b0, 3'b010, 1'b0, 1'b0);
    wd = 32'h1234; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    expect1("x0_write", 8'b0000_0011, 32'h0);
    #2 sample();

    // Reset wins over a write to x5; memory keeps its contents.
    wr_reg(5'd5, 32'h99);
    ins = {20'h0, 5'd5, 7'h33};
    wd = 32'h5555; RegWrite = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    drive({7'h0, 5'd0, 5'd5, 3'b000, 5'd0, 7'h33}, 1'b0, 3'b010, 1'b0, 1'b0);
    expect1("reset_wr", 8'b0000_0001, 32'h0);
    #2 sample();
    drive(32'h00C02203, 1'b1, 3'b010, 1'b1, 1'b0);
    expect1("mem_keep", 8'b1000_0000, 32'hAA);
    #2 sample();

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_decode_exec_mem.md
Name: rv_decode_exec_mem

Overview:
- Combined decode / execute / data-memory datapath slice of a single-cycle RV32I-subset CPU.
- Fetch stage supplies the 32-bit instruction. An external controller drives the control strobes.
- Decodes the register operands and immediates, runs the ALU, and accesses word-addressed data memory.
- The write-back value `wd` is returned from outside (ALU result or memory data, muxed externally).

Parameters:
- DM_WORDS, 1024: data-memory depth in 32-bit words. Power of two.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ins  in  32  current instruction
- wd  in  32  register-file write data
- RegWrite  in  1  register-file write enable
- ALUSrc  in  1  0: ALU operand B = rd2; 1: ALU operand B = imm
- op  in  3  ALU operation select
- MemRead  in  1  data-memory read enable
- MemWrite  in  1  data-memory write enable
- rd1  out  32  register[ins[19:15]]
- rd2  out  32  register[ins[24:20]]
- imm  out  32  opcode-selected immediate
- jTarget  out  32  J-type offset
- branch  out  32  B-type offset
- z  out  32  ALU result; also the data-memory byte address
- zero  out  1  1 when z == 0
- memOut  out  32  data-memory read data

Behaviour:
- Register file:
  - 32 x 32 bits. Reads are combinational.
  - x0 always reads 0; writes to x0 are ignored.
  - Write happens at posedge clk when RegWrite=1: reg[ins[11:7]] <= wd.
  - reset=1 at posedge clears all registers to 0. Reset has priority over a simultaneous write.
  - Read of the register being written returns the old value until the edge, then the new value.
- Immediate `imm`, selected by opcode ins[6:0], all sign-extended to 32 bits:
  - 0x03, 0x13, 0x67 (I-type): ins[31:20].
  - 0x23 (S-type): {ins[31:25], ins[11:7]}.
  - 0x63 (B-type): {ins[31], ins[7], ins[30:25], ins[11:8]}, a half-word offset with no implicit shift.
  - 0x37, 0x17 (U-type): {ins[31:12], 12'b0}.
  - 0x6F (J-type): same value as jTarget.
  - Any other opcode: imm = 0.
- branch: always the 12-bit B-type field above, sign-extended, regardless of opcode.
- jTarget: always {ins[31], ins[19:12], ins[20], ins[30:21]}, 20 bits sign-extended, no implicit shift. Caller scales it.
- ALU:
  - Operand A = rd1. Operand B = ALUSrc ? imm : rd2.
  - op 000 AND, 001 OR, 010 ADD, 110 SUB (A-B), 111 SLT (signed, z = 1 or 0).
  - Any other op code: z = 0.
  - ADD/SUB wrap modulo 2^32; no overflow flag.
  - zero = (z == 32'h0). Purely combinational.
- Data memory:
  - DM_WORDS words, indexed by z[log2(DM_WORDS)+1:2].
  - Low two address bits are ignored (word-aligned). Upper bits are ignored, so addresses wrap.
  - Read is combinational: memOut = MemRead ? mem[index] : 0.
  - Write at posedge clk when MemWrite=1: mem[index] <= rd2.
  - MemRead and MemWrite both 1: memOut shows the old word before the edge, the new word after.
  - Memory contents are not cleared by reset. Initial contents are 0 at simulation start.
- Latency:
  - All outputs are combinational from ins, the control inputs and current state; zero cycles.
  - State (registers, memory) updates take effect one clock edge later.
- Reset mid-operation: only the register file is cleared. ALU and memory outputs follow immediately from the zeroed register values.

Test Plan:
- Reset, then ins=0x00A00093 (addi x1,x0,10), ALUSrc=1, op=010 -> imm=10, z=10, zero=0. With wd=z, RegWrite=1, one clock -> next read of x1 = 10.
- x1=10, x2=10; ins=0x00208463 (beq x1,x2,+8), ALUSrc=0, op=110 -> z=0, zero=1, branch=4, imm=4.
- x1=10, x2=7; ins=0x0020A1B3 (slt x3,x1,x2), ALUSrc=0, op=111 -> z=0. Then x1=-1, op=111 -> z=1. op=010 with x1=0xFFFFFFFF, x2=1 -> z=0, zero=1.
- ins=0x0020A223 (sw x2,4(x1)), x1=8, x2=0x55, MemWrite=1, ALUSrc=1, op=010 -> imm=4, z=12. After the clock, ins=lw from address 12 with MemRead=1 -> memOut=0x55. With MemRead=0 -> memOut=0.
- ins=0x0100006F (jal x0,+16) -> jTarget=8, imm=8. ins with sign bit set, e.g. 0xFE000EE3 -> branch negative (0xFFFFFFFE... per field, sign-extended).
- RegWrite=1 with rd=x0 and wd=0x1234 -> x0 still reads 0. Assert reset together with RegWrite to x5 -> x5 reads 0 after the edge.
